// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: occupancy-state encoding and default payload field widths.
package pipe_skid_reg_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned RS_W      = 32;
    localparam int unsigned RT_W      = 32;
    localparam int unsigned EXT_W     = 32;
    localparam int unsigned PAYLOAD_W = INSTR_W + PC_W + RS_W + RT_W + EXT_W;

    // Encoding equals the entry count so occupancy is a direct view of the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [1:0] occ_of(input skid_state_e st);
        return logic'(st == ST_TWO) ? 2'd2 : (st == ST_ONE) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// Payload holding register with load enable and synchronous clear to the bubble value.
module pipe_slot
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned           DATA_W     = PAYLOAD_W,
    parameter logic [DATA_W-1:0]     BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            data_q <= BUBBLE_VAL;
        end else if (load) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: fully registered in_ready, flush, saturating stall counter.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned       DATA_W     = PAYLOAD_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_e       state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [DATA_W-1:0] m_q, s_q, m_d;
    logic              m_load, s_load, m_from_s;
    logic              accept, issue, slot_clr;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;
    assign slot_clr  = reset | flush;

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        s_load   = 1'b0;
        m_from_s = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    m_load  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && issue) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    state_d = ST_TWO;
                    s_load  = 1'b1;
                end else if (issue) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (issue) begin
                    state_d  = ST_ONE;
                    m_load   = 1'b1;
                    m_from_s = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    assign m_d = m_from_s ? s_q : in_data;

    // Counts every cycle a valid head is held back; flush does not clear it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_slot_m (
        .clk  (clk),
        .clr  (slot_clr),
        .load (m_load),
        .d    (m_d),
        .q    (m_q)
    );

    pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_slot_s (
        .clk  (clk),
        .clr  (slot_clr),
        .load (s_load),
        .d    (in_data),
        .q    (s_q)
    );

    assign out_data  = out_valid ? m_q : BUBBLE_VAL;
    assign occupancy = occ_of(state_q);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg with a narrow stall counter.
module tb_pipe_skid_reg;

    localparam int unsigned DW = 160;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_stall;

    logic [DW-1:0] dA, dB, dC, dD, dE, dF, dP, dQ, dX, dY;

    pipe_skid_reg #(
        .DATA_W     (DW),
        .BUBBLE_VAL ('0),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dA = {32'hA, 128'h0} | 160'hA0A0;
        dB = {32'hB, 128'h0} | 160'hB0B0;
        dC = 160'hC0C0_C0C0;
        dD = 160'hD0D0;
        dE = 160'hE0E0;
        dF = 160'hF0F0;
        dP = 160'h1234;
        dQ = 160'h5678;
        dX = 160'h9999;
        dY = 160'h7777;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check_eq("rst_out_valid", DW'(out_valid), '0);
        check_eq("rst_in_ready",  DW'(in_ready), 160'd1);
        check_eq("rst_occ",       DW'(occupancy), '0);
        check_eq("rst_out_data",  out_data, '0);
        check_eq("rst_stall",     DW'(stall_cnt), '0);

        // single word, next-cycle latency
        in_valid = 1'b1; in_data = 160'd1; out_ready = 1'b1;
        step();
        check_eq("lat_out_valid", DW'(out_valid), 160'd1);
        check_eq("lat_out_data",  out_data, 160'd1);
        check_eq("lat_occ",       DW'(occupancy), 160'd1);
        // accept and issue together keeps ONE and streams
        in_data = dP; step();
        check_eq("stream_p", out_data, dP);
        in_data = dQ; step();
        check_eq("stream_q", out_data, dQ);
        check_eq("stream_occ", DW'(occupancy), 160'd1);
        in_valid = 1'b0; step();
        check_eq("drain_occ", DW'(occupancy), '0);
        check_eq("drain_stall", DW'(stall_cnt), '0);

        // back-pressure fill
        out_ready = 1'b0; in_valid = 1'b1; in_data = dA;
        step();
        check_eq("fillA_occ",  DW'(occupancy), 160'd1);
        check_eq("fillA_data", out_data, dA);
        in_data = dB; step();
        check_eq("fillB_occ",   DW'(occupancy), 160'd2);
        check_eq("fillB_ready", DW'(in_ready), '0);
        check_eq("fillB_data",  out_data, dA);
        check_eq("fillB_stall", DW'(stall_cnt), 160'd1);
        in_data = dC;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("blk_data", out_data, dA);
            check_eq("blk_occ",  DW'(occupancy), 160'd2);
            check_eq("blk_stall", DW'(stall_cnt), DW'(2 + i));
        end

        // drain in order
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_eq("drn1_data",  out_data, dB);
        check_eq("drn1_occ",   DW'(occupancy), 160'd1);
        check_eq("drn1_ready", DW'(in_ready), 160'd1);
        check_eq("drn1_stall", DW'(stall_cnt), 160'd4);
        step();
        check_eq("drn2_occ",   DW'(occupancy), '0);
        check_eq("drn2_valid", DW'(out_valid), '0);
        check_eq("drn2_data",  out_data, '0);

        // flush while full with an incoming word
        out_ready = 1'b0; in_valid = 1'b1; in_data = dD; step();
        in_data = dE; step();
        check_eq("pre_fl_occ", DW'(occupancy), 160'd2);
        in_data = dF; flush = 1'b1; step();
        check_eq("fl_occ",   DW'(occupancy), '0);
        check_eq("fl_valid", DW'(out_valid), '0);
        check_eq("fl_data",  out_data, '0);
        check_eq("fl_stall", DW'(stall_cnt), 160'd6);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        check_eq("fl_no_f", DW'(out_valid), '0);

        // issue during a flush cycle still drains to empty
        in_valid = 1'b1; in_data = dP; out_ready = 1'b0; step();
        check_eq("fli_valid", DW'(out_valid), 160'd1);
        out_ready = 1'b1; flush = 1'b1; in_data = dQ; step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("fli_occ", DW'(occupancy), '0);
        check_eq("fli_stall", DW'(stall_cnt), 160'd6);

        // saturation
        in_valid = 1'b1; in_data = dX; out_ready = 1'b0; step();
        in_valid = 1'b0;
        exp_stall = 6;
        for (int i = 0; i < (1 << CW) + 5; i++) begin
            step();
            exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
            check_eq("sat_stall", DW'(stall_cnt), DW'(exp_stall));
        end
        check_eq("sat_final", DW'(stall_cnt), 160'hF);
        check_eq("sat_data",  out_data, dX);

        // reset beats flush and handshake
        in_valid = 1'b1; in_data = dY; step();
        check_eq("prerst_occ", DW'(occupancy), 160'd2);
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1; step();
        check_eq("rst2_occ",   DW'(occupancy), '0);
        check_eq("rst2_stall", DW'(stall_cnt), '0);
        check_eq("rst2_valid", DW'(out_valid), '0);
        check_eq("rst2_ready", DW'(in_ready), 160'd1);
        check_eq("rst2_data",  out_data, '0);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, 160, payload width (INSTR 32 + PC 32 + RsData 32 + RtData 32 + EXT 32).
REQ-002 Parameter BUBBLE_VAL, all-zero DATA_W vector, value on out_data whenever no entry is valid.
REQ-003 Parameter CNT_W, 16, width of the stall-cycle counter.
REQ-004 Port clk  input  1  clock; all state updates on posedge clk.
REQ-005 Port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-006 Port in_valid  input  1  upstream stage offers in_data.
REQ-007 Port in_ready  output  1  block can accept a word this cycle.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port flush  input  1  discard all held and incoming words (branch/exception kill).
REQ-010 Port out_valid  output  1  out_data holds a valid word.
REQ-011 Port out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 Port out_data  output  DATA_W  head word.
REQ-013 Port occupancy  output  2  entries held: 0, 1 or 2.
REQ-014 Port stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-015 Two storage entries: main M (head) and skid S; state EMPTY, ONE (M valid) or TWO (M and S valid).
REQ-016 accept = in_valid & in_ready; issue = out_valid & out_ready.
REQ-017 in_ready = (state != TWO), driven only from registered state; no combinational path from out_ready or in_valid.
REQ-018 out_valid = (state != EMPTY); out_data = M when out_valid, else BUBBLE_VAL.
REQ-019 EMPTY: accept -> ONE, M <= in_data; else stay EMPTY.
REQ-020 ONE: accept & issue -> ONE, M <= in_data; accept & !issue -> TWO, S <= in_data; !accept & issue -> EMPTY; neither -> hold.
REQ-021 TWO: issue -> ONE, M <= S; no accept is possible (in_ready low).
REQ-022 Latency: a word accepted in cycle n appears on out_data in cycle n+1 when the block was EMPTY or issued M in cycle n.
REQ-023 Words leave in acceptance order; none duplicated or lost except by flush.
REQ-024 While out_valid & !out_ready, out_data stays stable until issue.
REQ-025 flush has priority over all transitions: next state EMPTY, M and S <= BUBBLE_VAL; a word accepted in the flush cycle is dropped.
REQ-026 An issue in the flush cycle still counts as consumed downstream; flush does not suppress out_valid in that cycle.
REQ-027 occupancy = 0/1/2 for EMPTY/ONE/TWO, registered.
REQ-028 stall_cnt increments by 1 in each cycle with out_valid & !out_ready; it saturates at 2^CNT_W-1 and is unaffected by flush.

Reset
REQ-029 While reset is high at a posedge: state EMPTY; M, S = BUBBLE_VAL; stall_cnt = 0.
REQ-030 Reset overrides flush and any handshake in the same cycle.
REQ-031 Output values one cycle after reset: out_valid 0, in_ready 1, occupancy 0, out_data BUBBLE_VAL.

Structure
REQ-032 A shared pipeline package holds the state encoding typedef (EMPTY/ONE/TWO) and the default payload-field width constants.
REQ-033 One sub-module, pipe_slot: DATA_W register with load enable and synchronous clear-to-BUBBLE_VAL, instantiated for M and S.

Verification
REQ-034 Reset, then in_valid=1 with data 0x...0001 and out_ready=1 -> out_valid=1 next cycle with 0x...0001; occupancy 1.
REQ-035 out_ready=0; offer A then B -> occupancy 2 and in_ready=0; C stays blocked; out_data=A for all stall cycles; stall_cnt counts those cycles.
REQ-036 From TWO, raise out_ready for 2 cycles -> A then B issued in order; occupancy 2->1->0; in_ready high again after the first issue.
REQ-037 Full (TWO) with in_valid=1 and flush=1 -> next cycle occupancy 0, out_valid 0, out_data BUBBLE_VAL; the flush-cycle word is never issued.
REQ-038 Hold out_valid=1 with out_ready=0 for 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones, no wrap.
REQ-039 Assert reset with occupancy 2 and flush=1 -> state EMPTY and stall_cnt 0 the following cycle.
